// File: rtl/crc_pkg.sv
// Shared types and defaults for the bit-serial CRC-8 engine.
package crc_pkg;
  localparam int CRC_W = 8;

  localparam logic [CRC_W-1:0] POLY_DEF   = 8'h07;
  localparam logic [CRC_W-1:0] INIT_DEF   = 8'h00;
  localparam logic [CRC_W-1:0] XOROUT_DEF = 8'h00;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } crc_state_e;
endpackage

// File: rtl/cmos_xor.sv
// Two-input XOR cell used for every CRC feedback tap.
module cmos_xor (
  input  logic a,
  input  logic b,
  output logic y
);
  assign y = a ^ b;
endmodule

// File: rtl/crc8_lfsr_step.sv
// One MSB-first LFSR step: feedback from lfsr[7]^din_bit, XOR taps where POLY has ones.
module crc8_lfsr_step
  import crc_pkg::*;
#(
  parameter logic [CRC_W-1:0] POLY = POLY_DEF
) (
  input  logic [CRC_W-1:0] lfsr,
  input  logic             din_bit,
  output logic [CRC_W-1:0] lfsr_nxt
);
  logic fb;

  cmos_xor u_fb (.a(lfsr[CRC_W-1]), .b(din_bit), .y(fb));

  // Bit 0 has no lower neighbour, so it is either the feedback or zero.
  assign lfsr_nxt[0] = fb & POLY[0];

  for (genvar i = 1; i < CRC_W; i++) begin : g_tap
    if (POLY[i]) begin : g_xor
      cmos_xor u_tap (.a(lfsr[i-1]), .b(fb), .y(lfsr_nxt[i]));
    end else begin : g_wire
      assign lfsr_nxt[i] = lfsr[i-1];
    end
  end
endmodule

// File: rtl/crc8_serial_engine.sv
// Bit-serial CRC-8: accepts bytes on a valid/ready port, shifts MSB-first, holds the CRC until taken.
module crc8_serial_engine
  import crc_pkg::*;
#(
  parameter logic [CRC_W-1:0] POLY   = POLY_DEF,
  parameter logic [CRC_W-1:0] INIT   = INIT_DEF,
  parameter logic [CRC_W-1:0] XOROUT = XOROUT_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [CRC_W-1:0] din,
  input  logic             din_valid,
  input  logic             din_last,
  output logic             din_ready,
  output logic [CRC_W-1:0] crc_out,
  output logic             crc_valid,
  input  logic             crc_ready,
  output logic             busy
);
  crc_state_e       state_q, state_d;
  logic [CRC_W-1:0] lfsr_q, lfsr_d, lfsr_step;
  logic [CRC_W-1:0] sh_q, sh_d;
  logic [2:0]       cnt_q, cnt_d;
  logic             last_q, last_d;
  logic             first_q, first_d;

  crc8_lfsr_step #(.POLY(POLY)) u_step (
    .lfsr     (lfsr_q),
    .din_bit  (sh_q[CRC_W-1]),
    .lfsr_nxt (lfsr_step)
  );

  always_comb begin
    state_d = state_q;
    lfsr_d  = lfsr_q;
    sh_d    = sh_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    first_d = first_q;
    case (state_q)
      IDLE: begin
        if (din_valid) begin
          sh_d    = din;
          last_d  = din_last;
          cnt_d   = 3'd7;
          state_d = SHIFT;
          if (first_q) begin
            lfsr_d  = INIT;
            first_d = 1'b0;
          end
        end
      end
      SHIFT: begin
        lfsr_d = lfsr_step;
        sh_d   = {sh_q[CRC_W-2:0], 1'b0};
        cnt_d  = cnt_q - 3'd1;
        if (cnt_q == 3'd0) state_d = last_q ? DONE : IDLE;
      end
      DONE: begin
        if (crc_ready) begin
          state_d = IDLE;
          first_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      lfsr_q  <= INIT;
      sh_q    <= '0;
      cnt_q   <= '0;
      last_q  <= 1'b0;
      first_q <= 1'b1;
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_d;
      sh_q    <= sh_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      first_q <= first_d;
    end
  end

  // Outputs come only from flops, never from the input handshake.
  assign din_ready = (state_q == IDLE);
  assign crc_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign crc_out   = lfsr_q ^ XOROUT;
endmodule

// File: tb/tb_crc8_serial_engine.sv
// Directed bench for crc8_serial_engine: default instance plus an INIT/XOROUT=FF instance on shared stimulus.
module tb_crc8_serial_engine;
  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] din;
  logic       din_valid, din_last, crc_ready;
  logic       din_ready, crc_valid, busy;
  logic [7:0] crc_out;
  logic       din_ready2, crc_valid2, busy2;
  logic [7:0] crc_out2;

  int n_chk  = 0;
  int n_pass = 0;
  logic [7:0] fbuf [0:15];

  always #5 clk = ~clk;

  crc8_serial_engine dut (
    .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid), .din_last(din_last),
    .din_ready(din_ready), .crc_out(crc_out), .crc_valid(crc_valid),
    .crc_ready(crc_ready), .busy(busy)
  );

  crc8_serial_engine #(.INIT(8'hFF), .XOROUT(8'hFF)) dut_ff (
    .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid), .din_last(din_last),
    .din_ready(din_ready2), .crc_out(crc_out2), .crc_valid(crc_valid2),
    .crc_ready(crc_ready), .busy(busy2)
  );

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Sends fbuf[0..n-1] with din_valid held, checks 8-cycle busy windows and the final CRC.
  task automatic run_frame(input int n, input logic [7:0] exp, input string tag);
    for (int j = 0; j < n; j++) begin
      din       = fbuf[j];
      din_last  = (j == n - 1);
      din_valid = 1'b1;
      for (int g = 0; g < 40 && !din_ready; g++) tick();
      chk({tag, "_rdy"}, 8'(din_ready), 8'h01);
      tick();
      if (j == n - 1) din_valid = 1'b0;
      for (int i = 0; i < 8; i++) begin
        chk({tag, "_shift"}, 8'({din_ready, crc_valid, busy}), 8'h01);
        tick();
      end
      if (j < n - 1) chk({tag, "_rdy8"}, 8'({din_ready, crc_valid}), 8'h02);
    end
    chk({tag, "_valid"}, 8'(crc_valid), 8'h01);
    chk({tag, "_crc"}, crc_out, exp);
  endtask

  task automatic handoff(input string tag);
    crc_ready = 1'b1;
    tick();
    chk({tag, "_idle"}, 8'({din_ready, crc_valid, busy}), 8'h04);
  endtask

  initial begin
    rst_n = 1'b0; din = 8'h00; din_valid = 1'b0; din_last = 1'b0; crc_ready = 1'b1;
    tick(); tick();
    rst_n = 1'b1;
    tick();
    chk("rst_flags", 8'({din_ready, crc_valid, busy}), 8'h04);
    chk("rst_crc", crc_out, 8'h00);
    chk("rst_crc_ff", crc_out2, 8'h00);

    fbuf[0] = 8'h01; run_frame(1, 8'h07, "b01"); handoff("b01");
    fbuf[0] = 8'h80; run_frame(1, 8'h89, "b80"); handoff("b80");
    fbuf[0] = 8'h00; run_frame(1, 8'h00, "b00");
    chk("b00_ff", crc_out2, 8'h0C);
    handoff("b00");

    for (int j = 0; j < 9; j++) fbuf[j] = 8'h31 + 8'(j);
    run_frame(9, 8'hF4, "chk9"); handoff("chk9");

    // Stall in DONE with noise on the input port.
    crc_ready = 1'b0;
    fbuf[0] = 8'h80; run_frame(1, 8'h89, "stall");
    din = 8'hAA; din_last = 1'b1;
    for (int i = 0; i < 20; i++) begin
      din_valid = i[0];
      tick();
      chk("stall_hold", crc_out, 8'h89);
      chk("stall_flags", 8'({din_ready, crc_valid, busy}), 8'h03);
    end
    din_valid = 1'b0;
    handoff("stall");
    fbuf[0] = 8'h01; run_frame(1, 8'h07, "reload"); handoff("reload");

    // Reset lands on the 4th shift edge of the first byte.
    din = 8'h31; din_last = 1'b0; din_valid = 1'b1;
    chk("mid_rdy", 8'(din_ready), 8'h01);
    tick();
    din_valid = 1'b0;
    tick(); tick(); tick();
    rst_n = 1'b0;
    tick();
    chk("mid_rst_flags", 8'({din_ready, crc_valid, busy}), 8'h04);
    chk("mid_rst_crc", crc_out, 8'h00);
    chk("mid_rst_crc_ff", crc_out2, 8'h00);
    rst_n = 1'b1;
    tick();
    fbuf[0] = 8'h01; run_frame(1, 8'h07, "post_rst"); handoff("post_rst");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
